qubit_measure: RTL and testbench
================================

// Module: qubit_measure
// PURPOSE
//   Downstream consumer of the single-qubit gate stage (hadamard). Takes one
//   real amplitude pair (amp0 = <0|psi>, amp1 = <1|psi>) in fixed point.
//   Computes the Born probabilities and draws an outcome from an internal LFSR.
//   Emits the measured bit and the collapsed basis state on a valid/ready stream.
// PARAMETERS
//   WIDTH      `FIXED_WIDTH               signed amplitude width, two's complement
//   FRAC       $clog2(`SCALE_FACTOR)      fractional bits; 1.0 == `SCALE_FACTOR
//   LFSR_RESET 32'h0000_0001              LFSR value after reset
// PORTS
//   clk        in   1      single clock; all state updates on posedge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      input amplitude pair valid
//   in_ready   out  1      block can accept a pair (high only in IDLE)
//   in_amp0    in   WIDTH  signed amplitude of |0>
//   in_amp1    in   WIDTH  signed amplitude of |1>
//   seed_load  in   1      load seed into LFSR (honoured in IDLE only)
//   seed       in   32     LFSR seed
//   out_valid  out  1      result valid; held until out_ready
//   out_ready  in   1      downstream accepts result
//   out_bit    out  1      measured outcome: 0 -> |0>, 1 -> |1>
//   out_amp0   out  WIDTH  collapsed amplitude of |0>
//   out_amp1   out  WIDTH  collapsed amplitude of |1>
//   out_prob0  out  WIDTH  P(0) = amp0^2 (unsigned value in signed container)
//   out_err    out  1      zero-norm input (P0+P1 == 0)
// BEHAVIOUR
//   - Reset: state=IDLE, lfsr=LFSR_RESET, all outputs 0; in_ready=1 the cycle after rst drops.
//   - rst mid-operation aborts the sample; no out_valid is produced for it.
//   - FSM states: IDLE -> SQUARE -> SAMPLE -> DONE -> IDLE.
//   - IDLE
//       - in_valid & in_ready captures in_amp0/in_amp1 -> SQUARE.
//       - seed_load in the same cycle is also applied: lfsr = (seed==0) ? 1 : seed.
//   - seed_load outside IDLE is ignored.
//   - SQUARE
//       - p0 = (amp0*amp0) >>> FRAC and p1 = (amp1*amp1) >>> FRAC; 2*WIDTH product, truncating.
//       - Each result saturates to 2^(WIDTH-1)-1.
//       - -> SAMPLE.
//   - SAMPLE
//       - sum = p0+p1 (WIDTH+1 bits); u = lfsr[FRAC-1:0]; r = (u*sum) >> FRAC, so r < sum.
//       - Outcome: out_bit = (r < p0) ? 0 : 1.
//       - out_amp0/out_amp1 = {`SCALE_FACTOR, 0} for bit 0, {0, `SCALE_FACTOR} for bit 1.
//       - out_prob0 = p0.
//       - If sum==0: out_err=1, out_bit=0, both amps 0.
//       - LFSR advances exactly once here (Galois, taps 32'h8020_0003).
//       - -> DONE.
//   - DONE
//       - out_valid=1; all out_* stable while out_valid & !out_ready.
//       - out_valid & out_ready -> IDLE; out_valid drops next cycle.
//   - Latency: accept at cycle N -> out_valid at N+3. Throughput: one pair per >=4 cycles.
//   - in_ready=0 in SQUARE/SAMPLE/DONE; in_valid there is not consumed (source must hold).
//   - Outputs are registered; no combinational in->out path.
// TESTING
//   1 amp0=`SCALE_FACTOR, amp1=0, 64 samples
//       -> out_bit=0 every time; out_prob0=`SCALE_FACTOR; out_amp0=`SCALE_FACTOR, out_amp1=0.
//   2 amp0=0, amp1=-`SCALE_FACTOR, 64 samples
//       -> out_bit=1 every time; out_prob0=0; out_amp1=`SCALE_FACTOR.
//   3 amp0=amp1=`FIXED_POINT_CONST_0_7071, seed=32'hACE1, 1000 samples
//       -> out_prob0 within 2 LSB of 0.5; count of bit 0 in [450,550].
//       -> reseed with 32'hACE1 and rerun: identical bit sequence.
//   4 amp0=amp1=0 -> out_err=1, out_bit=0, both amps 0; the next valid input clears out_err.
//   5 hold out_ready=0 for 10 cycles in DONE -> out_* unchanged, in_ready=0.
//       -> out_ready=1: exactly one transfer, out_valid drops next cycle.
//   6 assert rst in SAMPLE -> no out_valid, lfsr=LFSR_RESET, in_ready=1 after rst drops.
//       -> seed_load=1 with seed=0 -> lfsr=1.

Source files
------------

// File: rtl/qubit_measure.sv
// Born-rule measurement of one real amplitude pair: squares the amplitudes,
// draws an outcome from a Galois LFSR and streams the collapsed basis state.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 16384
`endif

module qubit_measure #(
  parameter int          WIDTH      = `FIXED_WIDTH,
  parameter int          FRAC       = $clog2(`SCALE_FACTOR),
  parameter logic [31:0] LFSR_RESET = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_amp0,
  input  logic signed [WIDTH-1:0] in_amp1,
  input  logic                    seed_load,
  input  logic [31:0]             seed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic signed [WIDTH-1:0] out_amp0,
  output logic signed [WIDTH-1:0] out_amp1,
  output logic signed [WIDTH-1:0] out_prob0,
  output logic                    out_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SQUARE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0]             TAPS    = 32'h8020_0003;
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(`SCALE_FACTOR);
  localparam logic [WIDTH-1:0]        SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // Squared amplitude rescaled to FRAC bits, clipped to the largest positive value.
  function automatic logic [WIDTH-1:0] square_sat(input logic signed [WIDTH-1:0] a);
    logic signed [2*WIDTH-1:0] ext;
    logic signed [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0]        shifted;
    ext     = {{WIDTH{a[WIDTH-1]}}, a};
    prod    = ext * ext;
    shifted = $unsigned(prod >>> FRAC);
    if (|shifted[2*WIDTH-1:WIDTH-1]) begin
      return SAT_MAX;
    end else begin
      return shifted[WIDTH-1:0];
    end
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  state_t                    state_r, state_next_s;
  logic [31:0]               lfsr_r;
  logic signed [WIDTH-1:0]   amp0_r, amp1_r;
  logic [WIDTH-1:0]          p0_r, p1_r;
  logic                      in_ready_r, out_valid_r;
  logic                      in_fire_s;
  logic [WIDTH:0]            sum_s, r_s;
  logic [FRAC+WIDTH:0]       scaled_s;
  logic                      bit_s;

  assign in_fire_s = in_valid & in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

  // Uniform draw scaled into [0, sum) and compared against P(0).
  always_comb begin
    sum_s    = {1'b0, p0_r} + {1'b0, p1_r};
    scaled_s = {{(WIDTH+1){1'b0}}, lfsr_r[FRAC-1:0]} * {{FRAC{1'b0}}, sum_s};
    r_s      = scaled_s[FRAC+WIDTH:FRAC];
    bit_s    = (r_s < {1'b0, p0_r}) ? 1'b0 : 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = in_fire_s ? SQUARE : IDLE;
      SQUARE:  state_next_s = SAMPLE;
      SAMPLE:  state_next_s = DONE;
      DONE:    state_next_s = (out_valid_r & out_ready) ? IDLE : DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Datapath, LFSR and result registers (results only change in SAMPLE).
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r    <= LFSR_RESET;
      amp0_r    <= '0;
      amp1_r    <= '0;
      p0_r      <= '0;
      p1_r      <= '0;
      out_bit   <= 1'b0;
      out_amp0  <= '0;
      out_amp1  <= '0;
      out_prob0 <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (seed_load) begin
            lfsr_r <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
          end
          if (in_fire_s) begin
            amp0_r <= in_amp0;
            amp1_r <= in_amp1;
          end
        end
        SQUARE: begin
          p0_r <= square_sat(amp0_r);
          p1_r <= square_sat(amp1_r);
        end
        SAMPLE: begin
          lfsr_r    <= lfsr_step(lfsr_r);
          out_prob0 <= $signed(p0_r);
          if (sum_s == '0) begin
            out_err  <= 1'b1;
            out_bit  <= 1'b0;
            out_amp0 <= '0;
            out_amp1 <= '0;
          end else begin
            out_err  <= 1'b0;
            out_bit  <= bit_s;
            out_amp0 <= bit_s ? '0 : ONE;
            out_amp1 <= bit_s ? ONE : '0;
          end
        end
        DONE: begin
          lfsr_r <= lfsr_r;
        end
        default: begin
          lfsr_r <= lfsr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qubit_measure.sv
// Directed bench for qubit_measure with immediate-assertion checks.
`ifndef FIXED_POINT_CONST_0_7071
`define FIXED_POINT_CONST_0_7071 11585
`endif

module tb_qubit_measure;
  localparam int W = 16;
  localparam logic signed [W-1:0] ONE = 16'sd16384;
  localparam logic signed [W-1:0] H   = `FIXED_POINT_CONST_0_7071;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, seed_load, out_valid, out_ready, out_bit, out_err;
  logic signed [W-1:0] in_amp0, in_amp1, out_amp0, out_amp1, out_prob0;
  logic [31:0] seed;

  int tests = 0;
  int fails = 0;
  int lat;
  bit seq_a [1000];

  qubit_measure dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_amp0(in_amp0), .in_amp1(in_amp1), .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_amp0(out_amp0), .out_amp1(out_amp1), .out_prob0(out_prob0), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one pair, then wait (bounded) for the result; leaves it pending.
  task automatic send(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_amp0 = a0; in_amp1 = a1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (n >= 20) check("out_valid_timeout", 64'(out_valid), 64'd1);
    lat = n;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int c0, bad, mism, xfers, chg;
    logic [W-1:0] h_a0, h_a1, h_p;
    logic h_b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; seed_load = 1'b0; seed = 32'h0;
    in_amp0 = '0; in_amp1 = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prob0", 64'(out_prob0), 64'd0);
    check("rst_lfsr", 64'(dut.lfsr_r), 64'd1);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Test 1: certain |0>, also checks latency once.
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      send(ONE, 16'sd0);
      if (i == 0) check("latency", 64'(lat), 64'd2);
      if (out_bit !== 1'b0 || out_prob0 !== ONE || out_amp0 !== ONE || out_amp1 !== 16'sd0) bad++;
      take();
    end
    check("t1_bad_count", 64'(bad), 64'd0);

    // Test 2: certain |1> from a negative amplitude.
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      send(16'sd0, -ONE);
      if (out_bit !== 1'b1 || out_prob0 !== 16'sd0 || out_amp1 !== ONE || out_amp0 !== 16'sd0) bad++;
      take();
    end
    check("t2_bad_count", 64'(bad), 64'd0);

    // Saturation: (-1.0*2)^2 clips to 32767 and is all P(0).
    send(-16'sd32768, 16'sd0);
    check("sat_prob0", 64'(out_prob0), 64'h7fff);
    check("sat_bit", 64'(out_bit), 64'd0);
    take();

    // Test 3: equal superposition, seeded; then reseed and compare sequences.
    seed = 32'h0000_ACE1; seed_load = 1'b1; tick(); seed_load = 1'b0;
    check("seed_acе1_loaded", 64'(dut.lfsr_r), 64'h0000_ACE1);
    c0 = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      send(H, H);
      seq_a[i] = out_bit;
      if (!out_bit) c0++;
      if (out_prob0 < 16'sd8190 || out_prob0 > 16'sd8194) bad++;
      take();
    end
    check("t3_prob0_range", 64'(bad), 64'd0);
    check("t3_prob0_exact", 64'(out_prob0), 64'd8191);
    check("t3_count0_in_range", 64'(c0 >= 450 && c0 <= 550), 64'd1);
    seed = 32'h0000_ACE1; seed_load = 1'b1; tick(); seed_load = 1'b0;
    mism = 0;
    for (int i = 0; i < 1000; i++) begin
      send(H, H);
      if (out_bit !== seq_a[i]) mism++;
      take();
    end
    check("t3_repeat_mism", 64'(mism), 64'd0);

    // Test 4: zero norm flags an error, next pair clears it.
    send(16'sd0, 16'sd0);
    check("t4_err", 64'(out_err), 64'd1);
    check("t4_bit", 64'(out_bit), 64'd0);
    check("t4_amps", 64'({out_amp0, out_amp1}), 64'd0);
    take();
    send(ONE, 16'sd0);
    check("t4_err_cleared", 64'(out_err), 64'd0);
    take();

    // Test 5: backpressure holds the result; one transfer on release.
    send(16'sd0, ONE);
    h_a0 = out_amp0; h_a1 = out_amp1; h_p = out_prob0; h_b = out_bit;
    chg = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || in_ready || out_amp0 !== h_a0 || out_amp1 !== h_a1 ||
          out_prob0 !== h_p || out_bit !== h_b) chg++;
    end
    check("t5_held_changes", 64'(chg), 64'd0);
    check("t5_held_value", 64'(out_amp1), 64'(ONE));
    out_ready = 1'b1;
    tick();
    check("t5_valid_dropped", 64'(out_valid), 64'd0);
    xfers = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) xfers++;
    end
    out_ready = 1'b0;
    check("t5_transfers", 64'(xfers), 64'd1);

    // Seed handling: IDLE load honoured, load while busy ignored.
    seed = 32'd5; seed_load = 1'b1; tick(); seed_load = 1'b0;
    check("seed5_loaded", 64'(dut.lfsr_r), 64'd5);
    in_amp0 = ONE; in_amp1 = 16'sd0; in_valid = 1'b1; tick(); in_valid = 1'b0;
    seed = 32'h1234; seed_load = 1'b1; tick(); tick(); seed_load = 1'b0;
    check("seed_busy_ignored", 64'(dut.lfsr_r), 64'h8020_0001);
    check("busy_in_ready", 64'(in_ready), 64'd0);
    take();

    // Test 6: reset during SAMPLE aborts the sample.
    in_amp0 = H; in_amp1 = H; in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick();
    check("t6_in_sample", 64'(dut.state_r), 64'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_lfsr_reset", 64'(dut.lfsr_r), 64'd1);
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) xfers++;
    end
    check("t6_no_out_valid", 64'(xfers), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    seed = 32'd0; seed_load = 1'b1; tick(); seed_load = 1'b0;
    check("t6_seed_zero", 64'(dut.lfsr_r), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
